instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/harvard_pkg.sv | 13 +
 rtl/program_counter.sv | 17 +
 rtl/instruction_fetch.sv | 64 ++++++
 tb/tb_instruction_fetch.sv | 137 +++++++++++++
 4 files changed

// File: rtl/harvard_pkg.sv
// harvard_pkg: shared instruction word layout and fetch FSM state encoding
package harvard_pkg;
  localparam int OPCODE_WIDTH = 5;
  localparam int OPERAND_WIDTH = 16;
  localparam int INSTR_WIDTH = 22;
  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 5'b11111;
  localparam int OPCODE_MSB = 21;
  localparam int OPCODE_LSB = 17;
  localparam int MODE_BIT = 16;
  localparam int OPERAND_MSB = 15;
  localparam int OPERAND_LSB = 0;
  typedef enum logic [1:0] {IDLE, FETCH, VALID, HALT} fetchState_t;
endpackage

// File: rtl/program_counter.sv
// program_counter: program address register with sync reset, load, increment and hold
module program_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             increment,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic [WIDTH-1:0] pc
);
  // holds whenever neither load nor increment is requested; increment wraps naturally
  always_ff @(posedge clock)
    if (reset) pc <= '0;
    else if (load) pc <= loadValue;
    else if (increment) pc <= pc + 1'b1;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch FSM feeding the decoder from a synchronous program ROM
module instruction_fetch
  import harvard_pkg::*;
#(
  parameter int PC_WIDTH = 8,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = harvard_pkg::HALT_OPCODE
) (
  input  logic                     ClockInput,
  input  logic                     ResetInput,
  output logic [PC_WIDTH-1:0]      ProgramAddressOutput,
  input  logic [INSTR_WIDTH-1:0]   ProgramDataInput,
  input  logic                     StallInput,
  input  logic                     JumpFlagInput,
  input  logic [PC_WIDTH-1:0]      JumpAddressInput,
  output logic [OPCODE_WIDTH-1:0]  OpecodeOutput,
  output logic                     AddressingModeOutput,
  output logic [OPERAND_WIDTH-1:0] OperandOutput,
  output logic                     InstructionValidOutput,
  output logic                     HaltedOutput
);
  fetchState_t state, nextState;
  logic [INSTR_WIDTH-1:0] ir;
  logic pcIncrement, pcLoad;
  program_counter #(.WIDTH(PC_WIDTH)) pcReg (
    .clock(ClockInput),
    .reset(ResetInput),
    .increment(pcIncrement),
    .load(pcLoad),
    .loadValue(JumpAddressInput),
    .pc(ProgramAddressOutput)
  );
  always_ff @(posedge ClockInput)
    if (ResetInput) begin
      state <= IDLE;
      ir <= '0;
    end else begin
      state <= nextState;
      if (state == FETCH) ir <= ProgramDataInput;
    end
  // stall outranks jump, jump outranks halt; HALT is only left through reset
  always_comb begin
    nextState = state;
    pcIncrement = 1'b0;
    pcLoad = 1'b0;
    case (state)
      IDLE: nextState = FETCH;
      FETCH: begin
        nextState = VALID;
        pcIncrement = 1'b1;
      end
      VALID:
        if (!StallInput) begin
          pcLoad = JumpFlagInput;
          nextState = JumpFlagInput ? IDLE : (ir[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) ? HALT : FETCH;
        end
      default: ;
    endcase
  end
  assign OpecodeOutput = ir[OPCODE_MSB:OPCODE_LSB];
  assign AddressingModeOutput = ir[MODE_BIT];
  assign OperandOutput = ir[OPERAND_MSB:OPERAND_LSB];
  assign InstructionValidOutput = state == VALID;
  assign HaltedOutput = state == HALT;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of the fetch FSM against a synchronous ROM model
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic jump = 1'b0;
  logic [7:0] jumpAddr = 8'h00;
  logic [7:0] addr;
  logic [21:0] romData = '0;
  logic [4:0] opcode;
  logic mode;
  logic [15:0] operand;
  logic valid, halted;
  logic [21:0] rom [0:255];
  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .ClockInput(clk),
    .ResetInput(rst),
    .ProgramAddressOutput(addr),
    .ProgramDataInput(romData),
    .StallInput(stall),
    .JumpFlagInput(jump),
    .JumpAddressInput(jumpAddr),
    .OpecodeOutput(opcode),
    .AddressingModeOutput(mode),
    .OperandOutput(operand),
    .InstructionValidOutput(valid),
    .HaltedOutput(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) romData <= rom[addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expectOut(input string tag, input logic v, input logic h, input logic [7:0] pc,
                           input logic [4:0] op, input logic md, input logic [15:0] opr);
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".halted"}, 32'(halted), 32'(h));
    chk({tag, ".pc"}, 32'(addr), 32'(pc));
    chk({tag, ".opcode"}, 32'(opcode), 32'(op));
    chk({tag, ".mode"}, 32'(mode), 32'(md));
    chk({tag, ".operand"}, 32'(operand), 32'(opr));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {5'b00001, 1'b0, 16'(i)};
    rom[0] = {5'b00011, 1'b0, 16'h0005};
    rom[1] = {5'b00100, 1'b1, 16'h0009};
    rom[2] = {5'b11111, 1'b0, 16'hBEEF};
    rom[8'h40] = {5'b00101, 1'b0, 16'h1234};
    rom[8'hFF] = {5'b00110, 1'b1, 16'h00FF};
    tick();
    expectOut("reset", 0, 0, 8'h00, 5'h00, 0, 16'h0000);
    rst = 1'b0;
    tick();
    expectOut("fetch0", 0, 0, 8'h00, 5'h00, 0, 16'h0000);
    tick();
    expectOut("valid0", 1, 0, 8'h01, 5'b00011, 0, 16'h0005);
    tick();
    expectOut("fetch1", 0, 0, 8'h01, 5'b00011, 0, 16'h0005);
    tick();
    expectOut("valid1", 1, 0, 8'h02, 5'b00100, 1, 16'h0009);
    stall = 1'b1;
    jump = 1'b1;
    jumpAddr = 8'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      expectOut($sformatf("stall%0d", i), 1, 0, 8'h02, 5'b00100, 1, 16'h0009);
    end
    stall = 1'b0;
    tick();
    expectOut("jumpIdle", 0, 0, 8'h40, 5'b00100, 1, 16'h0009);
    jump = 1'b0;
    tick();
    expectOut("jumpFetch", 0, 0, 8'h40, 5'b00100, 1, 16'h0009);
    tick();
    expectOut("jumpValid", 1, 0, 8'h41, 5'b00101, 0, 16'h1234);
    jump = 1'b1;
    jumpAddr = 8'hFF;
    tick();
    expectOut("wrapIdle", 0, 0, 8'hFF, 5'b00101, 0, 16'h1234);
    jumpAddr = 8'h10;
    tick();
    expectOut("jumpInIdle", 0, 0, 8'hFF, 5'b00101, 0, 16'h1234);
    tick();
    jump = 1'b0;
    expectOut("wrapValid", 1, 0, 8'h00, 5'b00110, 1, 16'h00FF);
    tick();
    expectOut("wrapFetch", 0, 0, 8'h00, 5'b00110, 1, 16'h00FF);
    rst = 1'b1;
    tick();
    expectOut("rstInFetch", 0, 0, 8'h00, 5'h00, 0, 16'h0000);
    rst = 1'b0;
    tick();
    tick();
    expectOut("rerun0", 1, 0, 8'h01, 5'b00011, 0, 16'h0005);
    tick();
    tick();
    expectOut("rerun1", 1, 0, 8'h02, 5'b00100, 1, 16'h0009);
    tick();
    tick();
    expectOut("haltValid", 1, 0, 8'h03, 5'b11111, 0, 16'hBEEF);
    tick();
    expectOut("halted", 0, 1, 8'h03, 5'b11111, 0, 16'hBEEF);
    jump = 1'b1;
    jumpAddr = 8'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      expectOut($sformatf("haltHold%0d", i), 0, 1, 8'h03, 5'b11111, 0, 16'hBEEF);
    end
    jump = 1'b0;
    rst = 1'b1;
    tick();
    expectOut("rstInHalt", 0, 0, 8'h00, 5'h00, 0, 16'h0000);
    rst = 1'b0;
    tick();
    expectOut("restartFetch", 0, 0, 8'h00, 5'h00, 0, 16'h0000);
    tick();
    expectOut("restartValid", 1, 0, 8'h01, 5'b00011, 0, 16'h0005);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
